// File: rtl/riscv_pkg.sv
// Shared core definitions for the fetch front end: datapath width, PC step,
// the fetch FSM state encoding and the {PC, instruction} queue entry.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  // Fetch FSM state encoding
  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // One buffered fetch: instruction plus the PC it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Word-align a byte address by clearing bits [1:0]
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of {PC, instr} entries for the prefetch queue.
// Ports: CLK/RST_N; i_push/i_data write an entry, i_pop retires the head,
// i_flush empties the queue (pointers only, storage untouched);
// o_count is the occupancy, o_head the registered head entry.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  fetch_entry_t           i_data,
  output logic [$clog2(DEPTH):0] o_count,
  output fetch_entry_t           o_head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_cnt_after_pop;
  logic          w_do_push;
  logic          w_do_pop;
  fetch_entry_t  r_head;
  fetch_entry_t  w_head_nxt;

  // Head register tracks whatever entry will sit at the read pointer next cycle
  always_comb begin
    w_do_pop        = i_pop & (r_count != '0) & ~i_flush;
    w_do_push       = i_push & ~i_flush;
    w_rd_ptr_nxt    = w_do_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
    w_cnt_after_pop = r_count - CW'(w_do_pop);
    w_head_nxt      = r_head;
    if (!i_flush) begin
      if (w_cnt_after_pop != '0) begin
        w_head_nxt = r_mem[w_rd_ptr_nxt];
      end else if (w_do_push) begin
        // Queue drains to empty (or was empty): the incoming word becomes head
        w_head_nxt = i_data;
      end
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge CLK) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and head register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      r_head <= w_head_nxt;
      if (i_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_rd_ptr <= w_rd_ptr_nxt;
        if (w_do_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
    end
  end

  assign o_count = r_count;
  assign o_head  = r_head;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch stage: issues in-order word fetches to a variable
// latency instruction memory, buffers responses with their PC and hands them
// to IF_ID under ValidF/ReadyF. PCSrcE flushes the queue, turns in-flight
// requests stale (drained in DRAIN) and redirects fetch to PCTargetE.
// Ports: CLK, RST_N (async active-low); IMemReq/IMemAddr/IMemGnt request
// handshake; IMemRValid/IMemRData in-order responses; PCSrcE/PCTargetE
// redirect; ValidF/ReadyF/InstrF/PCF/PCPlus4F toward IF_ID.
// Build option: FETCH_BYPASS_EN lets a response reach IF_ID in the same
// cycle when the queue is empty and IF_ID is ready.
module fetch_prefetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned    DEPTH    = 4,
  parameter int unsigned    MAX_OUT  = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            CLK,
  input  logic            RST_N,
  output logic            IMemReq,
  output logic [XLEN-1:0] IMemAddr,
  input  logic            IMemGnt,
  input  logic            IMemRValid,
  input  logic [XLEN-1:0] IMemRData,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            ValidF,
  input  logic            ReadyF,
  output logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F
);

  localparam int unsigned CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAXOUT_C = CW'(MAX_OUT);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [XLEN-1:0] r_next_pc;
  logic [XLEN-1:0] w_next_pc_nxt;
  logic [XLEN-1:0] r_resp_pc;      // PC of the oldest live outstanding request
  logic [XLEN-1:0] w_resp_pc_nxt;
  logic [CW-1:0]   r_out;
  logic [CW-1:0]   w_out_nxt;
  logic [CW-1:0]   r_stale;
  logic [CW-1:0]   w_stale_nxt;
  logic [CW-1:0]   w_inflight;
  logic [CW-1:0]   w_count;
  logic            w_req;
  logic            w_grant;
  logic            w_live_resp;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_push_data;
  fetch_entry_t    w_head;

  // Request credit, response routing and pop qualification
  always_comb begin
    w_req       = (r_state == ST_RUN) && ((w_count + r_out) < DEPTH_C) && (r_out < MAXOUT_C);
    w_grant     = w_req & IMemGnt;
    w_live_resp = IMemRValid & (r_state == ST_RUN) & (r_stale == '0) & ~PCSrcE;
`ifdef FETCH_BYPASS_EN
    w_bypass    = w_live_resp & (w_count == '0) & ReadyF;
`else
    w_bypass    = 1'b0;
`endif
    w_push      = w_live_resp & ~w_bypass;
    w_pop       = (w_count != '0) & ReadyF & ~PCSrcE;
    // Everything in flight this cycle, counting a same-cycle grant
    w_inflight  = r_stale + r_out + CW'(w_grant);
    w_push_data = '{pc: r_resp_pc, instr: IMemRData};
  end

  // Next-state and counter update
  always_comb begin
    w_state_nxt   = r_state;
    w_next_pc_nxt = r_next_pc;
    w_resp_pc_nxt = r_resp_pc;
    w_out_nxt     = r_out;
    w_stale_nxt   = r_stale;
    if (PCSrcE) begin
      w_next_pc_nxt = align_pc(PCTargetE);
      w_resp_pc_nxt = align_pc(PCTargetE);
      w_out_nxt     = '0;
      // A response arriving with the redirect retires one stale slot
      w_stale_nxt   = (IMemRValid && (w_inflight != '0)) ? w_inflight - CW'(1) : w_inflight;
      w_state_nxt   = (w_stale_nxt != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      case (r_state)
        ST_BOOT: begin
          w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (w_grant) begin
            w_next_pc_nxt = r_next_pc + PC_STEP;
          end
          if (w_live_resp) begin
            w_resp_pc_nxt = r_resp_pc + PC_STEP;
          end
          w_out_nxt = r_out + CW'(w_grant) - CW'(w_live_resp);
        end
        ST_DRAIN: begin
          if (IMemRValid && (r_stale != '0)) begin
            w_stale_nxt = r_stale - CW'(1);
          end
          if (w_stale_nxt == '0) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_BOOT;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch address and request bookkeeping
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_next_pc <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_out     <= '0;
      r_stale   <= '0;
    end else begin
      r_next_pc <= w_next_pc_nxt;
      r_resp_pc <= w_resp_pc_nxt;
      r_out     <= w_out_nxt;
      r_stale   <= w_stale_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (PCSrcE),
    .i_data  (w_push_data),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // IF_ID-facing outputs; the bypass path only overrides an empty queue
  assign IMemReq  = w_req;
  assign IMemAddr = r_next_pc;
  assign ValidF   = ((w_count != '0) & ~PCSrcE) | w_bypass;
  assign InstrF   = w_bypass ? IMemRData : w_head.instr;
  assign PCF      = w_bypass ? r_resp_pc : w_head.pc;
  assign PCPlus4F = PCF + PC_STEP;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: memory model with fixed
// latency, scoreboard of expected delivered PCs, a table of redirect
// scenarios and hand-written corner sequences.
module tb_fetch_prefetch_queue;

  logic        clk;
  logic        rst_n;
  logic        gnt, rvalid, pcsrc, ready;
  logic [31:0] rdata, tgt;
  logic        imem_req, valid_f;
  logic [31:0] imem_addr, instr_f, pc_f, pcp4_f;

  fetch_prefetch_queue dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .IMemReq    (imem_req),
    .IMemAddr   (imem_addr),
    .IMemGnt    (gnt),
    .IMemRValid (rvalid),
    .IMemRData  (rdata),
    .PCSrcE     (pcsrc),
    .PCTargetE  (tgt),
    .ValidF     (valid_f),
    .ReadyF     (ready),
    .InstrF     (instr_f),
    .PCF        (pc_f),
    .PCPlus4F   (pcp4_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FETCH_BYPASS_EN
  localparam int FIRST_VALID = 2;
`else
  localparam int FIRST_VALID = 3;
`endif

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    int          lat;
    int          ready_mode;   // 0 always, 1 never, 2 alternate, 3 random
    int          redir_at;
    logic [31:0] target;
    int          n_deliver;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc;
  int          lat;
  int          ready_mode;
  bit          gnt_en;
  int          stale_m;
  pend_t       pend[$];
  logic [31:0] sb[$];
  logic [31:0] exp_addr;

  bit          obs_req, obs_valid, obs_grant, obs_deliv, obs_rvalid;
  logic [31:0] obs_gaddr, obs_pc, obs_pcp4;

  vec_t vecs[5];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h13C0_FFEE;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample at negedge, update model/scoreboard
  task automatic step(input logic redir, input logic [31:0] target);
    pend_t       p;
    logic [31:0] e;
    int          stale_before;
    #1;
    pcsrc = redir;
    tgt   = target;
    gnt   = gnt_en;
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = 1'b0;
      2:       ready = cyc[0];
      default: ready = 1'(($urandom_range(0, 1)));
    endcase
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p      = pend.pop_front();
      rvalid = 1'b1;
      rdata  = mem_word(p.addr);
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0BAD_0BAD;
    end
    @(negedge clk);
    obs_req    = imem_req;
    obs_valid  = valid_f;
    obs_grant  = imem_req & gnt;
    obs_deliv  = valid_f & ready;
    obs_rvalid = rvalid;
    obs_gaddr  = imem_addr;
    obs_pc     = pc_f;
    obs_pcp4   = pcp4_f;
    if (redir) chk("validf_in_redirect", 32'(valid_f), 32'd0);
    if (obs_deliv) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_delivery: got PCF %h expected no delivery", pc_f);
      end else begin
        e = sb.pop_front();
        chk("pcf", pc_f, e);
        chk("instrf", instr_f, mem_word(e));
        chk("pcplus4f", pcp4_f, e + 32'd4);
      end
    end
    stale_before = stale_m;
    if (stale_before > 0 && !redir) chk("no_grant_in_drain", 32'(obs_grant), 32'd0);
    if (obs_rvalid && stale_m > 0) stale_m--;
    if (obs_grant) begin
      chk("imem_addr", imem_addr, exp_addr);
      pend.push_back('{addr: imem_addr, due: cyc + lat});
      if (!redir) begin
        sb.push_back(exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
    end
    if (redir) begin
      stale_m  = pend.size();
      sb.delete();
      exp_addr = {target[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_imemreq"}, 32'(imem_req), 32'd0);
    chk({tag, "_imemaddr"}, imem_addr, 32'h0);
    chk({tag, "_validf"}, 32'(valid_f), 32'd0);
    chk({tag, "_instrf"}, instr_f, 32'h0);
    chk({tag, "_pcf"}, pc_f, 32'h0);
    chk({tag, "_pcplus4f"}, pcp4_f, 32'h4);
  endtask

  // Reset the DUT and the memory/scoreboard model; returns just after release
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    pcsrc = 1'b0;  gnt = 1'b0;  rvalid = 1'b0;  ready = 1'b0;
    tgt   = 32'h0; rdata = 32'h0;
    pend.delete();
    sb.delete();
    stale_m  = 0;
    exp_addr = 32'h0;
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Run until the first delivery; report the first granted address too
  task automatic run_first(input int budget, output logic [31:0] gaddr,
                           output logic [31:0] dpc, output logic [31:0] dp4, output bit found);
    bit got_g;
    got_g = 1'b0;
    found = 1'b0;
    gaddr = 32'hDEAD_BEEF;
    dpc   = 32'hDEAD_BEEF;
    dp4   = 32'hDEAD_BEEF;
    for (int i = 0; i < budget && !found; i++) begin
      step(1'b0, 32'h0);
      if (obs_grant && !got_g) begin
        got_g = 1'b1;
        gaddr = obs_gaddr;
      end
      if (obs_deliv) begin
        found = 1'b1;
        dpc   = obs_pc;
        dp4   = obs_pcp4;
      end
    end
    chk("first_delivery_seen", 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          first, nvalid, grants, ndel;
    logic [31:0] ga, dp, d4, fpc, lpc;
    logic [31:0] held [4];
    bit          found;

    vecs[0] = '{lat: 1, ready_mode: 0, redir_at: 6,  target: 32'h0000_0100, n_deliver: 4,
                exp_first: 32'h0000_0100, exp_last: 32'h0000_010C};
    vecs[1] = '{lat: 2, ready_mode: 2, redir_at: 8,  target: 32'hFFFF_FFFC, n_deliver: 3,
                exp_first: 32'hFFFF_FFFC, exp_last: 32'h0000_0004};
    vecs[2] = '{lat: 3, ready_mode: 3, redir_at: 5,  target: 32'h0000_0102, n_deliver: 5,
                exp_first: 32'h0000_0100, exp_last: 32'h0000_0110};
    vecs[3] = '{lat: 1, ready_mode: 0, redir_at: 0,  target: 32'h0000_0040, n_deliver: 3,
                exp_first: 32'h0000_0040, exp_last: 32'h0000_0048};
    vecs[4] = '{lat: 4, ready_mode: 0, redir_at: 10, target: 32'h2000_0003, n_deliver: 6,
                exp_first: 32'h2000_0000, exp_last: 32'h2000_0014};

    rst_n = 1'b1;
    lat = 1; ready_mode = 0; gnt_en = 1'b1;

    // Latency 1, always ready: first ValidF timing and back-to-back delivery
    do_reset();
    lat = 1; ready_mode = 0; gnt_en = 1'b1;
    first = -1; nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0);
      if (obs_valid && first < 0) first = i;
      if (obs_valid) nvalid++;
    end
    chk("first_valid_cycle", 32'(first), 32'(FIRST_VALID));
    chk("b2b_valid_cycles", 32'(nvalid), 32'(12 - FIRST_VALID));

    // ReadyF held low: exactly DEPTH grants, then in-order release
    do_reset();
    lat = 2; ready_mode = 1; gnt_en = 1'b1;
    grants = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 32'h0);
      if (obs_grant) grants++;
    end
    chk("grants_ready_low", 32'(grants), 32'd4);
    chk("imemreq_full", 32'(obs_req), 32'd0);
    ready_mode = 0;
    ndel = 0;
    for (int i = 0; i < 20 && ndel < 4; i++) begin
      step(1'b0, 32'h0);
      if (obs_deliv) begin
        held[ndel] = obs_pc;
        ndel++;
      end
    end
    chk("held_delivered", 32'(ndel), 32'd4);
    for (int i = 0; i < ndel; i++) chk("held_pc_order", held[i], 32'(i * 4));

    // Redirect with three requests outstanding: stale responses drained
    do_reset();
    lat = 5; ready_mode = 0; gnt_en = 1'b1;
    for (int i = 0; i < 10 && pend.size() < 3; i++) step(1'b0, 32'h0);
    chk("outstanding_before_redirect", 32'(pend.size()), 32'd3);
    gnt_en = 1'b0;
    step(1'b1, 32'h0000_0100);
    chk("stale_after_redirect", 32'(stale_m), 32'd3);
    gnt_en = 1'b1;
    run_first(40, ga, dp, d4, found);
    chk("redir_first_addr", ga, 32'h0000_0100);
    chk("redir_first_pcf", dp, 32'h0000_0100);
    chk("redir_first_pcplus4", d4, 32'h0000_0104);

    // Redirect coincident with a response and a ValidF&ReadyF pop
    do_reset();
    lat = 1; ready_mode = 0; gnt_en = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
    chk("coinc_prev_valid", 32'(obs_valid), 32'd1);
    step(1'b1, 32'h0000_0080);
    chk("coinc_resp", 32'(obs_rvalid), 32'd1);
    run_first(40, ga, dp, d4, found);
    chk("coinc_next_pcf", dp, 32'h0000_0080);

    // Reset asserted mid-DRAIN with two stale requests
    do_reset();
    lat = 6; ready_mode = 0; gnt_en = 1'b1;
    for (int i = 0; i < 10 && pend.size() < 2; i++) step(1'b0, 32'h0);
    gnt_en = 1'b0;
    step(1'b1, 32'h0000_0300);
    step(1'b0, 32'h0);
    chk("drain_stale_count", 32'(stale_m), 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("drain_rst");
    do_reset();
    lat = 1; gnt_en = 1'b1;
    run_first(40, ga, dp, d4, found);
    chk("restart_first_addr", ga, 32'h0);
    chk("restart_first_pcf", dp, 32'h0);

    // Table of redirect scenarios
    for (int v = 0; v < 5; v++) begin
      do_reset();
      lat = vecs[v].lat; ready_mode = vecs[v].ready_mode; gnt_en = 1'b1;
      for (int i = 0; i < vecs[v].redir_at; i++) step(1'b0, 32'h0);
      step(1'b1, vecs[v].target);
      ndel = 0; fpc = 32'hDEAD_BEEF; lpc = 32'hDEAD_BEEF;
      for (int i = 0; i < 300 && ndel < vecs[v].n_deliver; i++) begin
        step(1'b0, 32'h0);
        if (obs_deliv) begin
          if (ndel == 0) fpc = obs_pc;
          lpc = obs_pc;
          ndel++;
        end
      end
      chk($sformatf("vec%0d_count", v), 32'(ndel), 32'(vecs[v].n_deliver));
      chk($sformatf("vec%0d_first_pc", v), fpc, vecs[v].exp_first);
      chk($sformatf("vec%0d_last_pc", v), lpc, vecs[v].exp_last);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
